plan_stream_tx: RTL and testbench

Transmit side of the plan-check interface. Holds a table of subscription plan records (cost, talk allowance, data allowance), each field 6 bits, and on `start` streams them one at a time to a downstream plan checker over a valid/ready handshake. After each plan it waits for the checker's single-bit verdict. Once every plan is checked it publishes the verdict vector and an any-match flag.

---
 rtl/plan_stream_tx.sv | 146 ++++++++++++++
 tb/tb_plan_stream_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/plan_stream_tx.sv
// plan_stream_tx: streams a small table of plan records to a checker
// over valid/ready and collects one verdict bit per plan.
module plan_stream_tx #(
  parameter int N_PLANS = 5,
  parameter int W       = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [2:0]         wr_idx,
  input  logic [W-1:0]       wr_cost,
  input  logic [W-1:0]       wr_talk,
  input  logic [W-1:0]       wr_data,
  input  logic               start,
  output logic               busy,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [2:0]         tx_idx,
  output logic [W-1:0]       tx_cost,
  output logic [W-1:0]       tx_talk,
  output logic [W-1:0]       tx_data,
  output logic               tx_last,
  input  logic               rsp_valid,
  input  logic               rsp_match,
  output logic               done,
  output logic [N_PLANS-1:0] match_vec,
  output logic               any_match
);

  localparam logic [3:0] LP_N    = 4'(N_PLANS);
  localparam logic [2:0] LP_LAST = 3'(N_PLANS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [W-1:0]       r_cost [N_PLANS];
  logic [W-1:0]       r_talk [N_PLANS];
  logic [W-1:0]       r_data [N_PLANS];
  logic [2:0]         r_idx;
  logic [N_PLANS-1:0] r_match;
  logic               r_any;

  logic               w_we;
  logic               w_send;
  logic               w_clr;
  logic               w_inc;
  logic               w_fin;
  logic [N_PLANS-1:0] w_vec;

  assign w_we = wr_en && (r_state == S_IDLE)
             && ({1'b0, wr_idx} < LP_N);

  // Table write port, usable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PLANS; i++) begin
        r_cost[i] <= '0;
        r_talk[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (w_we) begin
      r_cost[wr_idx] <= wr_cost;
      r_talk[wr_idx] <= wr_talk;
      r_data[wr_idx] <= wr_data;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Next state and datapath controls
  always_comb begin
    w_nxt = r_state;
    w_clr = 1'b0;
    w_inc = 1'b0;
    w_fin = 1'b0;
    w_vec = r_match;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt = S_SEND;
          w_clr = 1'b1;
        end
      end
      S_SEND: begin
        if (tx_ready) w_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_valid) begin
          w_vec[r_idx] = rsp_match;
          if (r_idx == LP_LAST) begin
            w_nxt = S_DONE;
            w_fin = 1'b1;
          end else begin
            w_nxt = S_SEND;
            w_inc = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Index, verdict vector and any-match flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_match <= '0;
      r_any   <= 1'b0;
    end else if (w_clr) begin
      r_idx   <= '0;
      r_match <= '0;
      r_any   <= 1'b0;
    end else begin
      r_match <= w_vec;
      if (w_inc) r_idx <= r_idx + 3'd1;
      if (w_fin) r_any <= |w_vec;
    end
  end

  assign w_send    = (r_state == S_SEND);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign tx_valid  = w_send;
  assign tx_idx    = w_send ? r_idx : 3'd0;
  assign tx_cost   = w_send ? r_cost[r_idx] : '0;
  assign tx_talk   = w_send ? r_talk[r_idx] : '0;
  assign tx_data   = w_send ? r_data[r_idx] : '0;
  assign tx_last   = w_send && (r_idx == LP_LAST);
  assign match_vec = r_match;
  assign any_match = r_any;

endmodule

// File: tb/tb_plan_stream_tx.sv
// tb_plan_stream_tx: directed and random passes through plan_stream_tx,
// checked against a table/verdict model held in the bench.
module tb_plan_stream_tx;

  localparam int N = 5;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [2:0]   wr_idx = '0;
  logic [W-1:0] wr_cost = '0;
  logic [W-1:0] wr_talk = '0;
  logic [W-1:0] wr_data = '0;
  logic         start = 1'b0;
  logic         tx_ready = 1'b0;
  logic         rsp_valid = 1'b0;
  logic         rsp_match = 1'b0;
  logic         busy;
  logic         tx_valid;
  logic [2:0]   tx_idx;
  logic [W-1:0] tx_cost;
  logic [W-1:0] tx_talk;
  logic [W-1:0] tx_data;
  logic         tx_last;
  logic         done;
  logic [N-1:0] match_vec;
  logic         any_match;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0] m_cost [N];
  logic [W-1:0] m_talk [N];
  logic [W-1:0] m_data [N];

  plan_stream_tx #(.N_PLANS(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_cost   (wr_cost),
    .wr_talk   (wr_talk),
    .wr_data   (wr_data),
    .start     (start),
    .busy      (busy),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_idx    (tx_idx),
    .tx_cost   (tx_cost),
    .tx_talk   (tx_talk),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .rsp_valid (rsp_valid),
    .rsp_match (rsp_match),
    .done      (done),
    .match_vec (match_vec),
    .any_match (any_match)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),      0);
    chk({tag, "_valid"}, 32'(tx_valid),  0);
    chk({tag, "_idx"},   32'(tx_idx),    0);
    chk({tag, "_cost"},  32'(tx_cost),   0);
    chk({tag, "_talk"},  32'(tx_talk),   0);
    chk({tag, "_data"},  32'(tx_data),   0);
    chk({tag, "_last"},  32'(tx_last),   0);
    chk({tag, "_done"},  32'(done),      0);
    chk({tag, "_vec"},   32'(match_vec), 0);
    chk({tag, "_any"},   32'(any_match), 0);
  endtask

  task automatic wr(input int idx, input int c, input int t, input int d);
    wr_en   = 1'b1;
    wr_idx  = 3'(idx);
    wr_cost = W'(c);
    wr_talk = W'(t);
    wr_data = W'(d);
    tick;
    wr_en = 1'b0;
    if (idx < N) begin
      m_cost[idx] = W'(c);
      m_talk[idx] = W'(t);
      m_data[idx] = W'(d);
    end
  endtask

  task automatic chk_rec(input string tag, input int i);
    chk({tag, "_valid"}, 32'(tx_valid), 1);
    chk({tag, "_idx"},   32'(tx_idx),   32'(i));
    chk({tag, "_cost"},  32'(tx_cost),  32'(m_cost[i]));
    chk({tag, "_talk"},  32'(tx_talk),  32'(m_talk[i]));
    chk({tag, "_data"},  32'(tx_data),  32'(m_data[i]));
    chk({tag, "_last"},  32'(tx_last),  32'(i == N - 1));
  endtask

  task automatic do_pass(input logic [N-1:0] v,
                         input int st_idx,
                         input int st_len,
                         input int rdly,
                         input bit noise,
                         input bit timed);
    int t0;
    logic [N-1:0] mask;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_vec",  32'(match_vec), 0);
    chk("start_any",  32'(any_match), 0);
    t0 = cyc;
    for (int i = 0; i < N; i++) begin
      chk_rec("rec", i);
      if (i == st_idx) begin
        for (int s = 0; s < st_len; s++) begin
          tx_ready = 1'b0;
          if (noise) begin
            start     = 1'b1;
            wr_en     = 1'b1;
            wr_idx    = 3'd0;
            wr_cost   = 6'd63;
            rsp_valid = 1'b1;
            rsp_match = 1'b1;
          end
          tick;
          start     = 1'b0;
          wr_en     = 1'b0;
          rsp_valid = 1'b0;
          rsp_match = 1'b0;
          chk_rec("stall", i);
        end
      end
      tx_ready = 1'b1;
      if (noise) begin
        rsp_valid = 1'b1;
        rsp_match = ~v[i];
      end
      tick;
      tx_ready  = 1'b0;
      rsp_valid = 1'b0;
      rsp_match = 1'b0;
      chk("wait_valid", 32'(tx_valid), 0);
      chk("wait_cost",  32'(tx_cost),  0);
      chk("wait_idx",   32'(tx_idx),   0);
      chk("wait_last",  32'(tx_last),  0);
      for (int d = 0; d < rdly; d++) begin
        tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
        chk("rdly_valid", 32'(tx_valid), 0);
      end
      rsp_valid = 1'b1;
      rsp_match = v[i];
      tick;
      rsp_valid = 1'b0;
      rsp_match = 1'b0;
      mask = N'((1 << (i + 1)) - 1);
      chk("part_vec", 32'(match_vec), 32'(v & mask));
    end
    chk("done_pulse", 32'(done),      1);
    chk("done_busy",  32'(busy),      1);
    chk("done_valid", 32'(tx_valid),  0);
    chk("done_vec",   32'(match_vec), 32'(v));
    chk("done_any",   32'(any_match), 32'(v != 0));
    if (timed) chk("pass_len", 32'(cyc - t0), 32'(2 * N));
    tick;
    chk("post_done", 32'(done),      0);
    chk("post_busy", 32'(busy),      0);
    chk("hold_vec",  32'(match_vec), 32'(v));
    chk("hold_any",  32'(any_match), 32'(v != 0));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_cost[i] = '0;
      m_talk[i] = '0;
      m_data[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_zero("por");
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Reset mid-pass while the third record is offered
    for (int i = 0; i < N; i++)
      wr(i, $urandom_range(1, 63), $urandom_range(1, 63),
         $urandom_range(1, 63));
    start = 1'b1;
    tick;
    start     = 1'b0;
    tx_ready  = 1'b1;
    rsp_valid = 1'b1;
    rsp_match = 1'b1;
    repeat (4) tick;
    chk("mid_valid", 32'(tx_valid),  1);
    chk("mid_idx",   32'(tx_idx),    2);
    chk("mid_vec",   32'(match_vec), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    tx_ready  = 1'b0;
    rsp_valid = 1'b0;
    rsp_match = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("rst_idle", 32'(busy), 0);
    for (int i = 0; i < N; i++) begin
      m_cost[i] = '0;
      m_talk[i] = '0;
      m_data[i] = '0;
    end
    do_pass(5'b01010, -1, 0, 0, 1'b0, 1'b1);

    // Directed table, full pass with ready held
    for (int i = 0; i < N; i++) wr(i, 18, 16 + i, 20 - i);
    do_pass(5'b00100, -1, 0, 0, 1'b0, 1'b1);

    // Backpressure on idx 1
    do_pass(5'b01001, 1, 4, 0, 1'b0, 1'b0);

    // No match
    do_pass(5'b00000, -1, 0, 0, 1'b0, 1'b1);

    // Ignored start/write/response mid-pass
    do_pass(5'b00110, 2, 3, 1, 1'b1, 1'b0);
    wr(6, 63, 63, 63);
    do_pass(5'b01110, -1, 0, 2, 1'b0, 1'b0);

    // Back-to-back pass
    do_pass(5'b10001, -1, 0, 0, 1'b0, 1'b1);

    // Random tables, verdicts and stalls
    repeat (6) begin
      for (int i = 0; i < N; i++)
        wr(i, $urandom_range(0, 63), $urandom_range(0, 63),
           $urandom_range(0, 63));
      do_pass(N'($urandom), $urandom_range(0, N - 1),
              $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
